// File: rtl/thunderbird_pkg.sv
// Shared state encoding and lamp patterns for the Thunderbird tail-light sequencer.
// Lamp vectors are ordered {lc, lb, la, ra, rb, rc}.
package thunderbird_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        L1   = 3'd1,
        L2   = 3'd2,
        L3   = 3'd3,
        R1   = 3'd4,
        R2   = 3'd5,
        R3   = 3'd6,
        LR3  = 3'd7
    } state_t;

    localparam logic [5:0] PAT_IDLE = 6'b000_000;
    localparam logic [5:0] PAT_L1   = 6'b001_000;
    localparam logic [5:0] PAT_L2   = 6'b011_000;
    localparam logic [5:0] PAT_L3   = 6'b111_000;
    localparam logic [5:0] PAT_R1   = 6'b000_100;
    localparam logic [5:0] PAT_R2   = 6'b000_110;
    localparam logic [5:0] PAT_R3   = 6'b000_111;
    localparam logic [5:0] PAT_LR3  = 6'b111_111;

    function automatic logic [5:0] lamp_pattern(input state_t s);
        logic [5:0] p;
        p = PAT_IDLE;
        case (s)
            L1:      p = PAT_L1;
            L2:      p = PAT_L2;
            L3:      p = PAT_L3;
            R1:      p = PAT_R1;
            R2:      p = PAT_R2;
            R3:      p = PAT_R3;
            LR3:     p = PAT_LR3;
            default: p = PAT_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous switch input.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/thunderbird_tail_fsm.sv
// Thunderbird tail-light sequencer: synchronised switches drive a Moore FSM
// that steps once per clk_en strobe, with registered lamp outputs.
//
// state | meaning
// IDLE  | all lamps off, waiting for a switch
// L1    | la on
// L2    | la, lb on
// L3    | la, lb, lc on
// R1    | ra on
// R2    | ra, rb on
// R3    | ra, rb, rc on
// LR3   | all six on (hazard, or left and right together)
module thunderbird_tail_fsm
    import thunderbird_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic left,
    input  logic right,
    input  logic haz,
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic busy
);

    logic   left_s;
    logic   right_s;
    logic   haz_s;
    state_t state;
    state_t next_state;
    logic [5:0] lamps;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_left (
        .clk (clk),
        .rst (rst),
        .d   (left),
        .q   (left_s)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_right (
        .clk (clk),
        .rst (rst),
        .d   (right),
        .q   (right_s)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_haz (
        .clk (clk),
        .rst (rst),
        .d   (haz),
        .q   (haz_s)
    );

    // Turn sequences run to completion unless the hazard switch pre-empts them.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (haz_s || (left_s && right_s)) begin
                    next_state = LR3;
                end else if (left_s) begin
                    next_state = L1;
                end else if (right_s) begin
                    next_state = R1;
                end else begin
                    next_state = IDLE;
                end
            end
            L1:      next_state = haz_s ? LR3 : L2;
            L2:      next_state = haz_s ? LR3 : L3;
            L3:      next_state = haz_s ? LR3 : IDLE;
            R1:      next_state = haz_s ? LR3 : R2;
            R2:      next_state = haz_s ? LR3 : R3;
            R3:      next_state = haz_s ? LR3 : IDLE;
            LR3:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Lamps and busy are decoded from next_state so they land on the same edge as state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lamps <= PAT_IDLE;
            busy  <= 1'b0;
        end else if (clk_en) begin
            state <= next_state;
            lamps <= lamp_pattern(next_state);
            busy  <= (next_state != IDLE);
        end
    end

    assign lc = lamps[5];
    assign lb = lamps[4];
    assign la = lamps[3];
    assign ra = lamps[2];
    assign rb = lamps[1];
    assign rc = lamps[0];

endmodule

// File: tb/tb_thunderbird_tail_fsm.sv
// Self-checking bench for thunderbird_tail_fsm: directed scenarios plus random
// stimulus compared every cycle against a sequence-level reference model.
module tb_thunderbird_tail_fsm;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic left, right, haz;
    logic la, lb, lc, ra, rb, rc;
    logic busy;

    int checks = 0;
    int errors = 0;

    thunderbird_tail_fsm #(.SYNC_STAGES(SYNC)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .left   (left),
        .right  (right),
        .haz    (haz),
        .la     (la),
        .lb     (lb),
        .lc     (lc),
        .ra     (ra),
        .rb     (rb),
        .rc     (rc),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] pat_now();
        return {lc, lb, la, ra, rb, rc};
    endfunction

    // Reference model: which side is lit (0 none, 1 left, 2 right, 3 both)
    // and how many lamps, plus the raw history each synchroniser has seen.
    int m_kind = 0;
    int m_step = 0;
    bit h_l[SYNC];
    bit h_r[SYNC];
    bit h_h[SYNC];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_kind = 0;
            m_step = 0;
            for (int i = 0; i < SYNC; i++) begin
                h_l[i] = 1'b0; h_r[i] = 1'b0; h_h[i] = 1'b0;
            end
        end else begin
            if (clk_en) begin
                if (m_kind == 0) begin
                    if (h_h[SYNC-1] || (h_l[SYNC-1] && h_r[SYNC-1])) begin
                        m_kind = 3; m_step = 3;
                    end else if (h_l[SYNC-1]) begin
                        m_kind = 1; m_step = 1;
                    end else if (h_r[SYNC-1]) begin
                        m_kind = 2; m_step = 1;
                    end
                end else if (m_kind == 3) begin
                    m_kind = 0; m_step = 0;
                end else if (h_h[SYNC-1]) begin
                    m_kind = 3; m_step = 3;
                end else if (m_step == 3) begin
                    m_kind = 0; m_step = 0;
                end else begin
                    m_step = m_step + 1;
                end
            end
            for (int i = SYNC - 1; i > 0; i--) begin
                h_l[i] = h_l[i-1]; h_r[i] = h_r[i-1]; h_h[i] = h_h[i-1];
            end
            h_l[0] = left; h_r[0] = right; h_h[0] = haz;
        end
    end

    function automatic logic [5:0] model_pat();
        int nl, nr;
        nl = (m_kind == 1 || m_kind == 3) ? m_step : 0;
        nr = (m_kind == 2 || m_kind == 3) ? m_step : 0;
        return {nl >= 3, nl >= 2, nl >= 1, nr >= 1, nr >= 2, nr >= 3};
    endfunction

    always @(negedge clk) begin
        chk("model_lamps", 32'(pat_now()), 32'(model_pat()));
        chk("model_busy", 32'(busy), 32'(m_kind != 0));
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_pat(input logic [5:0] target, input int max_cycles, input string tag);
        int n;
        n = 0;
        while (pat_now() !== target && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, 32'(pat_now()), 32'(target));
    endtask

    task automatic settle_idle();
        left = 1'b0; right = 1'b0; haz = 1'b0; clk_en = 1'b1;
        repeat (8) tick();
        chk("settle_idle", 32'(pat_now()), 32'h0);
    endtask

    logic [5:0] seq_exp[9];
    logic [5:0] cyc4[4];
    logic [5:0] got_q[$];
    int first_nz;

    initial begin
        rst = 1'b1; clk_en = 1'b0; left = 1'b0; right = 1'b0; haz = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_lamps", 32'(pat_now()), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // 1: asynchronous reset while in L2
        clk_en = 1'b1; left = 1'b1;
        wait_pat(6'b011_000, 20, "t1_reach_l2");
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_lamps", 32'(pat_now()), 32'h0);
        chk("t1_rst_busy", 32'(busy), 32'h0);
        left = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        chk("t1_after_lamps", 32'(pat_now()), 32'h0);
        chk("t1_after_busy", 32'(busy), 32'h0);

        // 2: clk_en 1-in-4 with left held
        cyc4[0] = 6'b001_000; cyc4[1] = 6'b011_000; cyc4[2] = 6'b111_000; cyc4[3] = 6'b000_000;
        left = 1'b1;
        got_q.delete();
        for (int c = 0; c < 48; c++) begin
            clk_en = (c % 4 == 0);
            tick();
            chk("t2_right_off", 32'(pat_now() & 6'b000_111), 32'h0);
            if (c % 4 == 0) got_q.push_back(pat_now());
        end
        first_nz = -1;
        for (int i = 0; i < got_q.size(); i++) begin
            if (first_nz < 0 && got_q[i] != 6'h0) first_nz = i;
        end
        chk("t2_started", 32'(first_nz >= 0 && first_nz < 3), 32'h1);
        if (first_nz >= 0) begin
            for (int i = first_nz; i < got_q.size(); i++) begin
                chk("t2_strobe_pat", 32'(got_q[i]), 32'(cyc4[(i - first_nz) % 4]));
            end
        end
        settle_idle();

        // 3: right pulsed for three clocks with clk_en tied high
        seq_exp = '{6'h00, 6'h00, 6'b000_100, 6'b000_110, 6'b000_111, 6'h00, 6'h00, 6'h00, 6'h00};
        right = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 2) right = 1'b0;
            chk("t3_right_seq", 32'(pat_now()), 32'(seq_exp[i]));
        end

        // 4: left and right together alternate all-on / all-off
        left = 1'b1; right = 1'b1;
        wait_pat(6'b111_111, 10, "t4_first_lr3");
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("t4_alternate", 32'(pat_now()), (i % 2 == 1) ? 32'h0 : 32'h3f);
        end
        settle_idle();

        // 5: hazard pre-empts the left sequence in L2
        left = 1'b1;
        got_q.delete();
        for (int c = 0; c < 40 && pat_now() !== 6'b011_000; c++) begin
            clk_en = (c % 4 == 0);
            tick();
        end
        chk("t5_reach_l2", 32'(pat_now()), 32'b011_000);
        haz = 1'b1;
        clk_en = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            clk_en = (c % 4 == 0);
            tick();
            if (c % 4 == 0) got_q.push_back(pat_now());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            chk("t5_haz_pat", 32'(got_q[i]), (i % 2 == 0) ? 32'h3f : 32'h0);
        end
        settle_idle();

        // 6: left toggling with no strobes changes nothing
        clk_en = 1'b0;
        for (int c = 0; c < 50; c++) begin
            left = ~left;
            tick();
        end
        chk("t6_lamps", 32'(pat_now()), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        settle_idle();

        // Random phase, with occasional asynchronous resets between edges
        for (int c = 0; c < 3000; c++) begin
            clk_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) left = ~left;
            if ($urandom_range(0, 7) == 0) right = ~right;
            if ($urandom_range(0, 15) == 0) haz = ~haz;
            if ($urandom_range(0, 499) == 0) begin
                #3 rst = 1'b1;
                #1;
                chk("rand_rst_lamps", 32'(pat_now()), 32'h0);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
